// File: rtl/alu_iter_rotator.sv
// Iterative rotate engine (ROL/ROR/RLC/RRC) with valid/ready request and response handshakes.
// Define ALU_ITER_ROTATOR_NIBBLE_STEP_EN to let ROL/ROR advance four positions per cycle.
module alu_iter_rotator #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [1:0]       req_op,
    input  logic [WIDTH-1:0] req_value,
    input  logic [WIDTH-1:0] req_count,
    input  logic [3:0]       req_flags,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_result,
    output logic [3:0]       rsp_flags,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW:0] W_CNT = (CW+1)'(WIDTH);
    localparam logic [CW:0] W_P1  = (CW+1)'(WIDTH + 1);
    localparam logic [CW:0] ONE   = (CW+1)'(1);
    localparam logic [CW:0] FOUR  = (CW+1)'(4);

    localparam logic [1:0] OP_ROL = 2'b00;
    localparam logic [1:0] OP_ROR = 2'b01;
    localparam logic [1:0] OP_RLC = 2'b10;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_next;
    logic [1:0]       op_q;
    logic [WIDTH-1:0] work_value;
    logic             work_carry;
    logic             carry_in_q;
    logic             count_nz;
    logic [CW:0]      remaining;

    logic [CW:0]      count_k, count_n;
    logic [WIDTH-1:0] step_value;
    logic             step_carry;
    logic [CW:0]      step_len;
    logic             nibble_ok;
    logic             flag_c;
    logic [3:0]       flags_next;

    logic unused_inputs;
    assign unused_inputs = ^{req_flags[3:1], req_count[WIDTH-1:CW+1]};

    // Carry rotates span WIDTH+1 bits, so their count folds modulo WIDTH+1.
    always_comb begin
        count_k = req_count[CW:0];
        if (req_op[1]) begin
            count_n = (count_k <= W_CNT) ? count_k : count_k - W_P1;
        end else begin
            count_n = {1'b0, req_count[CW-1:0]};
        end
    end

    always_comb begin
        step_value = work_value;
        step_carry = work_carry;
        step_len   = ONE;
`ifdef ALU_ITER_ROTATOR_NIBBLE_STEP_EN
        nibble_ok  = (remaining >= FOUR);
`else
        nibble_ok  = 1'b0;
`endif
        case (op_q)
            OP_ROL: begin
                if (nibble_ok) begin
                    step_value = (work_value << 4) | (work_value >> (WIDTH - 4));
                    step_len   = FOUR;
                end else begin
                    step_value = {work_value[WIDTH-2:0], work_value[WIDTH-1]};
                end
            end
            OP_ROR: begin
                if (nibble_ok) begin
                    step_value = (work_value >> 4) | (work_value << (WIDTH - 4));
                    step_len   = FOUR;
                end else begin
                    step_value = {work_value[0], work_value[WIDTH-1:1]};
                end
            end
            OP_RLC: begin
                step_value = {work_value[WIDTH-2:0], work_carry};
                step_carry = work_value[WIDTH-1];
            end
            default: begin
                step_value = {work_carry, work_value[WIDTH-1:1]};
                step_carry = work_value[0];
            end
        endcase
    end

    // A zero-length rotate hands the incoming carry straight through.
    always_comb begin
        flag_c = carry_in_q;
        if (count_nz) begin
            case (op_q)
                OP_ROL:  flag_c = work_value[0];
                OP_ROR:  flag_c = work_value[WIDTH-1];
                default: flag_c = work_carry;
            endcase
        end
        flags_next = {work_value[WIDTH-1], 1'b0, (work_value == '0), flag_c};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        req_ready  = 1'b0;
        rsp_valid  = 1'b0;
        busy       = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (remaining == '0) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                busy      = 1'b1;
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Working registers are loaded on accept, stepped in RUN and copied to the response once exhausted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q       <= '0;
            work_value <= '0;
            work_carry <= 1'b0;
            carry_in_q <= 1'b0;
            count_nz   <= 1'b0;
            remaining  <= '0;
            rsp_result <= '0;
            rsp_flags  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        op_q       <= req_op;
                        work_value <= req_value;
                        work_carry <= req_flags[0];
                        carry_in_q <= req_flags[0];
                        count_nz   <= (count_n != '0);
                        remaining  <= count_n;
                    end
                end
                RUN: begin
                    if (remaining == '0) begin
                        rsp_result <= work_value;
                        rsp_flags  <= flags_next;
                    end else begin
                        work_value <= step_value;
                        work_carry <= step_carry;
                        remaining  <= remaining - step_len;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/alu_iter_rotator.md
Name: alu_iter_rotator

Overview:
Multi-cycle rotate engine that executes rotate requests and returns the result with condition flags. It accepts a request over a valid/ready handshake, rotates the working value iteratively, then presents the result over a second valid/ready handshake. It sits beside the combinational Alu as a low-area rotate path for ROL/ROR/RLC/RRC. Flag encoding and rotate semantics match the ALU, so the same exhaustive compare benches run against it unchanged.

Parameters:
WIDTH, 32, word width in bits; must be a power of 2, at least 4.

Ports:
clk  in  1  clock; rising-edge.
rst_n  in  1  asynchronous active-low reset.
req_valid  in  1  request present.
req_ready  out  1  engine can accept a request.
req_op  in  2  00 ROL, 01 ROR, 10 RLC, 11 RRC.
req_value  in  WIDTH  operand to rotate.
req_count  in  WIDTH  rotate count.
req_flags  in  4  incoming flags; bit0 = carry in; bits 3:1 ignored.
rsp_valid  out  1  result present.
rsp_ready  in  1  consumer takes the result.
rsp_result  out  WIDTH  rotated value.
rsp_flags  out  4  {N,V,Z,C}: bit3 N, bit2 V, bit1 Z, bit0 C.
busy  out  1  high in RUN or DONE.

Behaviour:
- Clock and reset: one clock (clk). Reset is asynchronous and active-low (rst_n).
- States: IDLE, RUN, DONE.
- On reset, from any state including mid-RUN: state goes to IDLE. req_ready=1; rsp_valid=0; rsp_result=0; rsp_flags=0; busy=0. The in-flight request is discarded.
- IDLE: req_ready=1. When req_valid is high at a rising edge, the engine latches the value, op and carry-in, plus the effective count n, and moves to RUN.
- Effective count for ROL/ROR: req_count mod WIDTH, i.e. the low log2(WIDTH) bits.
- Effective count for RLC/RRC: take k = req_count[log2(WIDTH):0]. Then n = k if k ≤ WIDTH, else n = k-(WIDTH+1).
- RUN, each cycle:
  - If remaining = 0: latch the result and flags, go to DONE.
  - Otherwise rotate by one position and decrement remaining.
  - ROL/ROR rotate the WIDTH-bit value.
  - RLC/RRC rotate the (WIDTH+1)-bit {carry,value}. RLC moves the MSB into carry and the old carry into the LSB; RRC is the mirror.
- Latency: rsp_valid rises n+1 clock edges after the accept edge; n=0 gives 1 cycle.
- DONE: rsp_valid=1. rsp_result and rsp_flags are stable until a rising edge with rsp_ready=1, which returns the engine to IDLE. req_ready=0 in RUN and DONE, so there is no accept in the hand-back cycle. The next accept is possible one cycle after the hand-back.
- Flags:
  - N = result[WIDTH-1].
  - Z = (result == 0).
  - V = 0.
  - C for RLC/RRC: final carry bit.
  - C for ROL: result[0] when n>0.
  - C for ROR: result[WIDTH-1] when n>0.
  - C when n = 0: req_flags[0], passed through.
- rsp_result and rsp_flags hold their last value outside DONE.
- Inputs other than req_valid are don't-care unless req_valid is high in IDLE. rsp_ready is ignored outside DONE.

Optional Feature:
Macro ALU_ITER_ROTATOR_NIBBLE_STEP_EN.
- Defined:
  - In RUN, ROL/ROR advance 4 positions per cycle while remaining ≥ 4, otherwise 1.
  - Latency is floor(n/4) + (n mod 4) + 1.
  - RLC/RRC are unchanged at 1 position per cycle.
  - Results and flags are identical to the undefined build.
- Undefined: every op advances 1 position per cycle.

Test Plan:
- WIDTH=8, ROL 0x81 count 1, carry 0 -> rsp_result 0x03, flags N0 V0 Z0 C1, rsp_valid 2 cycles after accept.
- WIDTH=8, ROR 0x01 count 9 (n=1) -> 0x80, N1 C1 Z0. Then ROL 0x5A count 0, carry 1 -> 0x5A, C1, latency 1.
- WIDTH=8:
  - RLC 0x80 count 1, carry 0 -> 0x00, Z1 C1.
  - RRC 0x01 count 9 (n=0), carry 1 -> 0x01, C1, latency 1.
  - RRC 0x01 count 1, carry 1 -> 0x80, N1 C1.
- Backpressure: complete ROL 0x0F count 3, hold rsp_ready=0 for 5 cycles with req_valid=1 -> rsp_valid, result 0x78 and flags stable; req_ready=0 throughout; the new request is accepted only after hand-back.
- Reset: drop rst_n asynchronously mid-RUN (ROR count 6) -> outputs immediately at reset values with no clock needed; after release the engine accepts a fresh request normally.
- Exhaustive, WIDTH=8: every value × every count × all four ops × carry 0/1, against a software model. Run with and without the macro; results identical, latencies match their formulas.
